// File: rtl/uart_counter_tx.sv
// uart_counter_tx: serialises a DATA_WIDTH-bit counter snapshot onto a UART
// line as DATA_WIDTH/8 back-to-back 8N1 frames, least significant byte first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a word; s_ready high, tx high
// START | start bit (tx low) for CLKS_PER_BIT cycles
// DATA  | eight data bits of the current byte, bit 0 first
// STOP  | stop bit (tx high); then next byte's START or back to IDLE
module uart_counter_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [2:0]            bit_idx;
  logic [BYTE_W-1:0]     byte_idx;
  logic [7:0]            cur_byte;
  logic                  baud_end;

  // The latched word is kept intact; the byte on the wire is selected by index.
  assign cur_byte = shift_reg[{byte_idx, 3'b000} +: 8];
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Accept only in IDLE and never while reset is held.
  assign s_ready = (state == IDLE) && !reset;

  // Transmit sequencer; tx, busy and done are all registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            shift_reg <= s_data;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              // Next byte starts immediately: no idle gap inside a word.
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              byte_idx <= '0;
              state    <= IDLE;
              tx       <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
